// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM register, data-memory handshake FSM with timeout, MEM/WB register.
// Latency: one edge from EX/MEM capture to the W outputs, plus one edge per memory wait cycle.
// Backpressure: stall_M freezes EX/MEM and bubbles MEM/WB while an access waits or after a timeout.
module mem_stage #(
  parameter int N        = 64,
  parameter int MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic         zero_E,
  input  logic         Branch_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  input  logic         RegWrite_E,
  input  logic         MemtoReg_E,
  input  logic [4:0]   rd_E,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic [N-1:0] dm_rdata,
  input  logic         dm_ack,
  output logic         stall_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic         valid_W,
  output logic         RegWrite_W,
  output logic         MemtoReg_W,
  output logic [N-1:0] readData_W,
  output logic [N-1:0] aluResult_W,
  output logic [4:0]   rd_W,
  output logic         memError_M
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic         valid;
    logic         branch;
    logic         zero;
    logic         mem_read;
    logic         mem_write;
    logic         reg_write;
    logic         mem_to_reg;
    logic [4:0]   rd;
    logic [N-1:0] pc_branch;
    logic [N-1:0] alu_result;
    logic [N-1:0] write_data;
  } ex_mem_t;

  typedef struct packed {
    logic         valid;
    logic         reg_write;
    logic         mem_to_reg;
    logic [4:0]   rd;
    logic [N-1:0] alu_result;
    logic [N-1:0] read_data;
  } mem_wb_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  ex_mem_t         ex_mem_d, ex_mem_q;
  mem_wb_t         mem_wb_d, mem_wb_q;
  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            mem_op;
  logic            access_done;

  // A taken branch in MEM squashes whatever execute is presenting this cycle.
  always_comb begin
    ex_mem_d = '0;
    if (en_E && !PCSrc_M) begin
      ex_mem_d.valid      = 1'b1;
      ex_mem_d.branch     = Branch_E;
      ex_mem_d.zero       = zero_E;
      ex_mem_d.mem_read   = MemRead_E;
      ex_mem_d.mem_write  = MemWrite_E;
      ex_mem_d.reg_write  = RegWrite_E;
      ex_mem_d.mem_to_reg = MemtoReg_E;
      ex_mem_d.rd         = rd_E;
      ex_mem_d.pc_branch  = PCBranch_E;
      ex_mem_d.alu_result = aluResult_E;
      ex_mem_d.write_data = writeData_E;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_mem_q <= '0;
    end else if (!stall_M) begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign mem_op     = ex_mem_q.valid & (ex_mem_q.mem_read | ex_mem_q.mem_write);
  assign PCSrc_M    = ex_mem_q.valid & ex_mem_q.branch & ex_mem_q.zero;
  assign PCBranch_M = ex_mem_q.pc_branch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // The counter sits at zero in IDLE, so it is already cleared on entry to WAIT.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        wait_cnt_d = '0;
        if (mem_op && !dm_ack) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dm_ack) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == CW'(MAX_WAIT)) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    dm_req      = 1'b0;
    stall_M     = 1'b0;
    memError_M  = 1'b0;
    access_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        dm_req      = mem_op;
        access_done = mem_op & dm_ack;
        stall_M     = mem_op & ~dm_ack;
      end
      S_WAIT: begin
        dm_req      = 1'b1;
        access_done = dm_ack;
        stall_M     = ~dm_ack;
      end
      S_ERROR: begin
        stall_M    = 1'b1;
        memError_M = 1'b1;
      end
      default: begin
        dm_req = 1'b0;
      end
    endcase
  end

  assign dm_we    = dm_req & ex_mem_q.mem_write;
  assign dm_addr  = dm_req ? ex_mem_q.alu_result : '0;
  assign dm_wdata = dm_req ? ex_mem_q.write_data : '0;

  always_comb begin
    mem_wb_d = '0;
    if (!stall_M) begin
      mem_wb_d.valid      = ex_mem_q.valid;
      mem_wb_d.reg_write  = ex_mem_q.reg_write;
      mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
      mem_wb_d.rd         = ex_mem_q.rd;
      mem_wb_d.alu_result = ex_mem_q.alu_result;
      mem_wb_d.read_data  = (access_done && ex_mem_q.mem_read) ? dm_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_wb_q <= '0;
    end else begin
      mem_wb_q <= mem_wb_d;
    end
  end

  assign valid_W     = mem_wb_q.valid;
  assign RegWrite_W  = mem_wb_q.reg_write;
  assign MemtoReg_W  = mem_wb_q.mem_to_reg;
  assign rd_W        = mem_wb_q.rd;
  assign aluResult_W = mem_wb_q.alu_result;
  assign readData_W  = mem_wb_q.read_data;

endmodule
